// File: rtl/muldiv_pkg.sv
// Shared encodings, state type and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [DEFAULT_WIDTH-1:0] DIV0_LO = {DEFAULT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on {hi,lo}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] shl_s;
    logic [WIDTH:0] diff_s;

    // Multiply: lo holds the unprocessed multiplier, product bits shift in from the top.
    // Divide: lo holds the dividend, quotient bits shift in from the bottom.
    always_comb begin
        sum_s  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shl_s  = {hi_in, lo_in[WIDTH-1]};
        diff_s = shl_s - {1'b0, opnd};
        if (is_div) begin
            if (!diff_s[WIDTH]) begin
                hi_out = diff_s[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b1};
            end else begin
                hi_out = shl_s[WIDTH-1:0];
                lo_out = {lo_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_out = sum_s[WIDTH:1];
            lo_out = {sum_s[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               signed_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   step_hi_s;
    logic [WIDTH-1:0]   step_lo_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_neg_s;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? ({WIDTH{1'b0}} - v) : v;
    endfunction

    assign signed_s   = op_is_signed(op);
    assign a_mag_s    = neg_if(a, signed_s & a[WIDTH-1]);
    assign b_mag_s    = neg_if(b, signed_s & b[WIDTH-1]);
    assign prod_s     = {acc_hi_q, acc_lo_q};
    assign prod_neg_s = {(2*WIDTH){1'b0}} - prod_s;

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]   rem_mask_s;
    assign rem_mask_s = {WIDTH{1'b1}} >> cnt_q;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div_q),
        .hi_in  (acc_hi_q),
        .lo_in  (acc_lo_q),
        .opnd   (opnd_q),
        .hi_out (step_hi_s),
        .lo_out (step_lo_s)
    );

    // Next-state, datapath and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opnd_d    = opnd_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_div_d  = op_is_div(op);
                    neg_d     = signed_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rem_neg_d = signed_s & a[WIDTH-1];
                    div0_d    = op_is_div(op) & (b == {WIDTH{1'b0}});
                    a_d       = a;
                    acc_hi_d  = {WIDTH{1'b0}};
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = ST_CALC;
                    if (op_is_div(op)) begin
                        acc_lo_d = a_mag_s;
                        opnd_d   = b_mag_s;
                    end else begin
                        acc_lo_d = b_mag_s;
                        opnd_d   = a_mag_s;
`ifdef MULDIV_EARLY_OUT_EN
                        if (b_mag_s == {WIDTH{1'b0}}) begin
                            state_d = ST_FIX;
                        end else begin
                            state_d = ST_CALC;
                        end
`endif
                    end
                end else begin
                    if (hi_we) begin
                        hi_d = wdata;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (lo_we) begin
                        lo_d = wdata;
                    end else begin
                        lo_d = lo_q;
                    end
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
`ifdef MULDIV_EARLY_OUT_EN
                end else if (!is_div_q && ((acc_lo_q & rem_mask_s) == {WIDTH{1'b0}})) begin
                    // Remaining steps would only shift; do them all at once.
                    {acc_hi_d, acc_lo_d} = prod_s >> (WIDTH - int'(cnt_q));
                    state_d = ST_FIX;
`endif
                end else begin
                    acc_hi_d = step_hi_s;
                    acc_lo_d = step_lo_s;
                    cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (flush) begin
                    hi_d = hi_q;
                end else if (!is_div_q) begin
                    {hi_d, lo_d} = neg_q ? prod_neg_s : prod_s;
                end else if (div0_q) begin
                    lo_d = {WIDTH{1'b1}};
                    hi_d = a_q;
                end else begin
                    lo_d = neg_if(acc_lo_q, neg_q);
                    hi_d = neg_if(acc_hi_q, rem_neg_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_FIX) && !flush;
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            acc_hi_q  <= {WIDTH{1'b0}};
            acc_lo_q  <= {WIDTH{1'b0}};
            opnd_q    <= {WIDTH{1'b0}};
            a_q       <= {WIDTH{1'b0}};
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opnd_q    <= opnd_d;
            a_q       <= a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (fixed-latency build).
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cyc;
    int busy_cnt;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start (sampled on the next edge = cycle 0), then wait for done within a bound.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int dcyc, output int bcnt);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0;
        dcyc = 0;
        bcnt = 0;
        for (int c = 1; c <= 60; c++) begin
            if (busy) bcnt++;
            if (done) begin
                dcyc = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'h0; b = 32'h0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
        #12;
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_done", {31'h0, done}, 32'h0);
        check_eq("rst_hi", hi, 32'h0);
        check_eq("rst_lo", lo, 32'h0);
        rst_n = 1'b1;
        tick();

        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, done_cyc, busy_cnt);
        check_eq("mult_done_cyc", done_cyc, 32'd34);
        check_eq("mult_busy_cnt", busy_cnt, 32'd33);
        check_eq("mult_busy_at_done", {31'h0, busy}, 32'h0);
        check_eq("mult_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", lo, 32'hFFFF_FFFA);
        tick();
        check_eq("mult_done_pulse", {31'h0, done}, 32'h0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, done_cyc, busy_cnt);
        check_eq("multu_hi", hi, 32'hFFFF_FFFE);
        check_eq("multu_lo", lo, 32'h0000_0001);

        run_op(2'b00, 32'h0000_1234, 32'hFFFF_FFFF, done_cyc, busy_cnt);
        check_eq("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_neg_lo", lo, 32'hFFFF_EDCC);

        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, done_cyc, busy_cnt);
        check_eq("div_lo", lo, 32'hFFFF_FFFD);
        check_eq("div_hi", hi, 32'hFFFF_FFFF);

        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, done_cyc, busy_cnt);
        check_eq("div_negb_lo", lo, 32'hFFFF_FFFD);
        check_eq("div_negb_hi", hi, 32'h0000_0001);

        run_op(2'b11, 32'h0000_0064, 32'h0000_0000, done_cyc, busy_cnt);
        check_eq("div0_done_cyc", done_cyc, 32'd34);
        check_eq("div0_lo", lo, 32'hFFFF_FFFF);
        check_eq("div0_hi", hi, 32'h0000_0064);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, done_cyc, busy_cnt);
        check_eq("div_ovf_lo", lo, 32'h8000_0000);
        check_eq("div_ovf_hi", hi, 32'h0000_0000);

        // Preload both registers with one combined write.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_1111;
        tick();
        hi_we = 1'b0; lo_we = 1'b0;
        check_eq("preload_hi", hi, 32'h1111_1111);
        check_eq("preload_lo", lo, 32'h1111_1111);

        // MULTU 5x7 flushed at cycle 10, with an ignored start in the same cycle.
        op = 2'b01; a = 32'd5; b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_eq("flush_busy_c10", {31'h0, busy}, 32'h1);
        flush = 1'b1; start = 1'b1; a = 32'd9; b = 32'd9;
        tick();
        flush = 1'b0; start = 1'b0;
        check_eq("flush_busy_c11", {31'h0, busy}, 32'h0);
        check_eq("flush_done_c11", {31'h0, done}, 32'h0);
        check_eq("flush_hi", hi, 32'h1111_1111);
        check_eq("flush_lo", lo, 32'h1111_1111);
        run_op(2'b01, 32'd5, 32'd7, done_cyc, busy_cnt);
        check_eq("after_flush_cyc", done_cyc, 32'd34);
        check_eq("after_flush_lo", lo, 32'd35);
        check_eq("after_flush_hi", hi, 32'd0);

        // MTLO in IDLE.
        tick();
        lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        tick();
        lo_we = 1'b0;
        check_eq("mtlo_lo", lo, 32'hA5A5_A5A5);
        check_eq("mtlo_hi", hi, 32'd0);

        // Start with a simultaneous MTLO: write dropped; MTHI while busy dropped; reset at cycle 20.
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        start = 1'b0; lo_we = 1'b0;
        check_eq("start_busy_c1", {31'h0, busy}, 32'h1);
        check_eq("start_wins_lo", lo, 32'hA5A5_A5A5);
        for (int i = 0; i < 4; i++) tick();
        hi_we = 1'b1; wdata = 32'h1234_5678;
        tick();
        hi_we = 1'b0;
        check_eq("busy_write_hi", hi, 32'd0);
        for (int i = 0; i < 14; i++) tick();
        check_eq("pre_rst_busy", {31'h0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", {31'h0, busy}, 32'h0);
        check_eq("mid_rst_done", {31'h0, done}, 32'h0);
        check_eq("mid_rst_hi", hi, 32'h0);
        check_eq("mid_rst_lo", lo, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op(2'b11, 32'd100, 32'd7, done_cyc, busy_cnt);
        check_eq("recover_cyc", done_cyc, 32'd34);
        check_eq("recover_lo", lo, 32'd14);
        check_eq("recover_hi", hi, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
